uart_tx_fifo: RTL and testbench

//  UART transmitter with N-deep TX FIFO, 5..9 data bits, parity, 1/2 stop bits, break generation.

---
 rtl/uart_tx_fifo_pkg.sv | 47 ++++
 rtl/uart_tx_fifo_sync_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state codes,
// parity-select codes, the latched per-frame configuration and small decoders.
package uart_tx_fifo_pkg;

    localparam int unsigned TX_WORD_W = 9;
    localparam int unsigned STATE_W   = 3;
    localparam int unsigned WIDTH_W   = 4;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] ST_STOP1  = 3'd4;
    localparam logic [STATE_W-1:0] ST_STOP2  = 3'd5;

    localparam logic [1:0] PAR_ODD   = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_SPACE = 2'b10;
    localparam logic [1:0] PAR_MARK  = 2'b11;

    // Frame shape captured when a word is popped into the shifter.
    typedef struct packed {
        logic [WIDTH_W-1:0] width;
        logic               par_en;
        logic [1:0]         par_sel;
        logic               stop2;
    } frame_cfg_t;

    // Bits code 0..4 selects 5..9 data bits; codes 5..7 fall back to 9.
    function automatic logic [WIDTH_W-1:0] bits_to_width(input logic [2:0] code);
        return (code > 3'd4) ? 4'd9 : WIDTH_W'(code) + 4'd5;
    endfunction

    // Parity bit from the XOR of the data bits actually sent.
    function automatic logic parity_bit(input logic [1:0] sel, input logic acc);
        logic p;
        p = 1'b1;
        case (sel)
            PAR_ODD:   p = ~acc;
            PAR_EVEN:  p = acc;
            PAR_SPACE: p = 1'b0;
            PAR_MARK:  p = 1'b1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with synchronous flush.
// Ports: clk_i/rstn_i clock and async active-low reset; clr_i flush (wins over
// push/pop); push_i/wdata_i write; pop_i read-advance, rdata_o shows the head
// word; level_o/full_o/empty_o occupancy.
module uart_sync_fifo #(
    parameter int unsigned  DATA_W = 9,
    parameter int unsigned  DEPTH  = 16,
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [LVL_W-1:0]  level_o,
    output logic              full_o,
    output logic              empty_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer/level update; pointers wrap naturally as DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a TX FIFO: 5..9 data bits, optional parity,
// 1/2 stop bits, break generation. Frame shape is latched at frame start.
// Ports: clk_i/rstn_i; cfg_* live configuration; fifo_clr_i flush;
// tx_data_i/tx_valid_i/tx_ready_o push handshake (ready is combinational);
// tx_o registered serial line; busy_o shifter active; fifo_level_o/
// fifo_empty_o FIFO occupancy; tx_done_o one-clock end-of-frame pulse.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned  FIFO_DEPTH = 16,
    parameter int unsigned  DIV_W      = 16,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 cfg_en_i,
    input  logic [DIV_W-1:0]     cfg_div_i,
    input  logic                 cfg_parity_en_i,
    input  logic [1:0]           cfg_parity_sel_i,
    input  logic [2:0]           cfg_bits_i,
    input  logic                 cfg_stop_bits_i,
    input  logic                 cfg_break_i,
    input  logic                 fifo_clr_i,
    input  logic [TX_WORD_W-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic [LVL_W-1:0]     fifo_level_o,
    output logic                 fifo_empty_o,
    output logic                 tx_done_o
);
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [TX_WORD_W-1:0] fifo_rdata;

    assign tx_ready_o   = cfg_en_i & ~fifo_full & ~fifo_clr_i;
    assign fifo_push    = tx_valid_i & tx_ready_o;
    assign fifo_empty_o = fifo_empty;

    uart_sync_fifo #(
        .DATA_W (TX_WORD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clr_i   (fifo_clr_i),
        .push_i  (fifo_push),
        .wdata_i (tx_data_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .level_o (fifo_level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    logic [STATE_W-1:0]   state_q, state_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d, div_q, div_d;
    frame_cfg_t           fcfg_q, fcfg_d;
    logic [WIDTH_W-1:0]   bidx_q, bidx_d;
    logic [TX_WORD_W-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 hold_q, hold_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    logic                 bit_end, can_start, start, last, line;
    logic [DIV_W-1:0]     cnt_next;

    assign tx_o      = tx_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign tx_done_o = done_q;

    // Next-state, baud counter, shifter and line value.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        fcfg_d   = fcfg_q;
        bidx_d   = bidx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        hold_d   = hold_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        start    = 1'b0;
        last     = 1'b0;
        line     = 1'b1;

        bit_end   = (cnt_q == '0);
        can_start = cfg_en_i & ~fifo_empty & ~cfg_break_i & ~fifo_clr_i;
        cnt_next  = bit_end ? div_q : cnt_q - DIV_W'(1);
        if (state_q != ST_IDLE) cnt_d = cnt_next;

        case (state_q)
            ST_IDLE: begin
                // After break, hold mark for a full bit period before popping.
                if (cfg_break_i) begin
                    hold_d = 1'b1;
                    cnt_d  = cfg_div_i;
                end else if (hold_q) begin
                    if (bit_end) hold_d = 1'b0;
                    else         cnt_d  = cnt_q - DIV_W'(1);
                end else begin
                    start = can_start;
                end
            end
            ST_START: if (bit_end) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bidx_q == fcfg_q.width - WIDTH_W'(1)) begin
                        bidx_d  = '0;
                        state_d = fcfg_q.par_en ? ST_PARITY : ST_STOP1;
                    end else begin
                        bidx_d = bidx_q + WIDTH_W'(1);
                    end
                end
            end
            ST_PARITY: if (bit_end) state_d = ST_STOP1;
            ST_STOP1: begin
                if (bit_end) begin
                    if (fcfg_q.stop2) state_d = ST_STOP2;
                    else              last    = 1'b1;
                end
            end
            ST_STOP2: if (bit_end) last = 1'b1;
            default:  state_d = ST_IDLE;
        endcase

        // Frame end: go straight to START when another word is available.
        if (last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            start   = can_start;
        end

        if (start) begin
            fifo_pop       = 1'b1;
            state_d        = ST_START;
            cnt_d          = cfg_div_i;
            div_d          = cfg_div_i;
            fcfg_d.width   = bits_to_width(cfg_bits_i);
            fcfg_d.par_en  = cfg_parity_en_i;
            fcfg_d.par_sel = cfg_parity_sel_i;
            fcfg_d.stop2   = cfg_stop_bits_i;
            shift_d        = fifo_rdata;
            bidx_d         = '0;
            par_d          = 1'b0;
        end

        // Disable aborts the frame in flight without a done pulse.
        if (!cfg_en_i && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end

        // Line level follows the state being entered so tx_o tracks state_q.
        case (state_d)
            ST_IDLE:   line = ~cfg_break_i;
            ST_START:  line = 1'b0;
            ST_DATA:   line = shift_d[0];
            ST_PARITY: line = parity_bit(fcfg_d.par_sel, par_d);
            default:   line = 1'b1;
        endcase
        tx_d = line;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            fcfg_q  <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            hold_q  <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            fcfg_q  <= fcfg_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            hold_q  <= hold_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed frames plus randomized
// configurations, each frame compared against a bit-list model of the line.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH    = 16;
    localparam int          WAIT_MAX = 3000;

    typedef struct packed {
        logic [15:0] div;
        logic [2:0]  bits;
        logic        pe;
        logic [1:0]  ps;
        logic        s2;
    } cfg_t;

    logic       clk, rstn, en, brk, clr, valid;
    logic [8:0] data;
    cfg_t       cur, alt;
    logic       tx_ready, tx, busy, empty, done;
    logic [4:0] level;

    int         n_chk, n_bad, frames_done, pulses;
    logic [8:0] mq[$];

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .cfg_en_i         (en),
        .cfg_div_i        (cur.div),
        .cfg_parity_en_i  (cur.pe),
        .cfg_parity_sel_i (cur.ps),
        .cfg_bits_i       (cur.bits),
        .cfg_stop_bits_i  (cur.s2),
        .cfg_break_i      (brk),
        .fifo_clr_i       (clr),
        .tx_data_i        (data),
        .tx_valid_i       (valid),
        .tx_ready_o       (tx_ready),
        .tx_o             (tx),
        .busy_o           (busy),
        .fifo_level_o     (level),
        .fifo_empty_o     (empty),
        .tx_done_o        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rstn === 1'b1 && done === 1'b1) pulses <= pulses + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic cfg_t mk_cfg(input logic [15:0] dv, input logic [2:0] b, input logic pe,
                                    input logic [1:0] ps, input logic s2);
        cfg_t c;
        c.div = dv; c.bits = b; c.pe = pe; c.ps = ps; c.s2 = s2;
        return c;
    endfunction

    // Reference frame: list of line levels, one entry per bit period.
    function automatic int build_frame(input logic [8:0] w, input cfg_t c, output logic [12:0] f);
        int n, width, ones;
        logic p;
        width = (c.bits > 3'd4) ? 9 : int'(c.bits) + 5;
        f = '0;
        n = 1;                       // f[0] = start bit (0)
        ones = 0;
        for (int i = 0; i < width; i++) begin
            f[n] = w[i];
            ones += int'(w[i]);
            n++;
        end
        if (c.pe) begin
            case (c.ps)
                2'd0:    p = ((ones % 2) == 0);
                2'd1:    p = ((ones % 2) == 1);
                2'd2:    p = 1'b0;
                default: p = 1'b1;
            endcase
            f[n] = p;
            n++;
        end
        f[n] = 1'b1;
        n++;
        if (c.s2) begin
            f[n] = 1'b1;
            n++;
        end
        return n;
    endfunction

    task automatic push(input logic [8:0] w);
        data  = w;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Wait for a start bit, then sample every clock of the frame.
    // act 1: flush with concurrent push; act 2: switch live config to alt.
    task automatic expect_frame(input string tag, input logic [8:0] w, input cfg_t c,
                                input int act_at, input int act, output int waited);
        logic [12:0] ef, of;
        logic        uns;
        int          n, sample;
        n = build_frame(w, c, ef);
        waited = 0;
        while (tx !== 1'b0 && waited < WAIT_MAX) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " start"}, 32'(tx), 32'd0);
        if (tx !== 1'b0) return;
        check({tag, " busy"}, 32'(busy), 32'd1);
        of = '0;
        uns = 1'b0;
        sample = 0;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k <= int'(c.div); k++) begin
                if (k == 0) of[b] = tx;
                else if (tx !== of[b]) uns = 1'b1;
                if (sample == act_at) begin
                    if (act == 1) begin clr = 1'b1; valid = 1'b1; data = 9'h0AA; end
                    if (act == 2) cur = alt;
                end else if (sample == act_at + 1 && act == 1) begin
                    clr = 1'b0;
                    valid = 1'b0;
                end
                sample++;
                @(negedge clk);
            end
        end
        check({tag, " bits"}, 32'(of), 32'(ef));
        check({tag, " stable"}, 32'(uns), 32'd0);
        check({tag, " done"}, 32'(done), 32'd1);
        frames_done++;
    endtask

    // Release break and expect every queued word, back to back.
    task automatic drain(input string tag);
        int waited, k;
        logic [8:0] w;
        k = 0;
        brk = 1'b0;
        @(negedge clk);
        check({tag, " mark"}, 32'(tx), 32'd1);
        while (mq.size() > 0) begin
            w = mq.pop_front();
            expect_frame(tag, w, cur, -1, 0, waited);
            if (k == 0) check({tag, " mark len"}, 32'(waited + 1 >= int'(cur.div) + 1), 32'd1);
            else        check({tag, " gap"}, 32'(waited), 32'd0);
            k++;
        end
    endtask

    task automatic watch_idle(input string tag, input int ncyc);
        logic low;
        low = 1'b0;
        repeat (ncyc) begin
            @(negedge clk);
            if (tx !== 1'b1) low = 1'b1;
        end
        check(tag, 32'(low), 32'd0);
    endtask

    initial begin
        int         waited, k;
        logic [8:0] w, a, b;
        logic       exp_rdy;
        cfg_t       saved;
        n_chk = 0; n_bad = 0; frames_done = 0; pulses = 0;
        en = 1'b0; brk = 1'b0; clr = 1'b0; valid = 1'b0; data = '0;
        cur = mk_cfg(16'd3, 3'd3, 1'b0, 2'd0, 1'b0);
        alt = cur;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst tx", 32'(tx), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst level", 32'(level), 32'd0);
        check("rst empty", 32'(empty), 32'd1);
        check("rst done", 32'(done), 32'd0);
        check("rst ready", 32'(tx_ready), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("en ready", 32'(tx_ready), 32'd1);

        // 8N1, div=3
        push(9'h055);
        expect_frame("8n1", 9'h055, cur, -1, 0, waited);
        check("8n1 lat", 32'(waited), 32'd1);
        check("8n1 busy end", 32'(busy), 32'd0);
        check("8n1 empty", 32'(empty), 32'd1);

        // 5E2
        cur = mk_cfg(16'd2, 3'd0, 1'b1, 2'd1, 1'b1);
        push(9'h013);
        expect_frame("5e2", 9'h013, cur, -1, 0, waited);
        check("5e2 lat", 32'(waited), 32'd1);

        // 9O1, div=0
        cur = mk_cfg(16'd0, 3'd4, 1'b1, 2'd0, 1'b0);
        push(9'h1FF);
        expect_frame("9o1", 9'h1FF, cur, -1, 0, waited);
        check("9o1 lat", 32'(waited), 32'd1);

        // Fill past full under break, then release
        cur = mk_cfg(16'd1, 3'd3, 1'b0, 2'd0, 1'b0);
        brk = 1'b1;
        @(negedge clk);
        check("brk line", 32'(tx), 32'd0);
        for (int i = 0; i < int'(DEPTH) + 1; i++) begin
            w = 9'($urandom);
            exp_rdy = (mq.size() < int'(DEPTH));
            check("full rdy", 32'(tx_ready), 32'(exp_rdy));
            push(w);
            if (exp_rdy) mq.push_back(w);
        end
        check("full lvl", 32'(level), 32'(mq.size()));
        check("full rdy end", 32'(tx_ready), 32'd0);
        check("brk line hold", 32'(tx), 32'd0);
        drain("full");
        check("full empty", 32'(empty), 32'd1);
        check("full busy", 32'(busy), 32'd0);
        watch_idle("full none", 30);

        // Randomized configurations
        for (int r = 0; r < 6; r++) begin
            cur = mk_cfg(16'($urandom_range(0, 4)), 3'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)));
            brk = 1'b1;
            @(negedge clk);
            k = int'($urandom_range(1, 5));
            for (int i = 0; i < k; i++) begin
                w = 9'($urandom);
                push(w);
                mq.push_back(w);
            end
            check("rnd lvl", 32'(level), 32'(k));
            drain("rnd");
        end

        // Mid-frame config change affects only the next frame
        cur = mk_cfg(16'd2, 3'd3, 1'b0, 2'd0, 1'b0);
        alt = mk_cfg(16'd1, 3'd2, 1'b1, 2'd1, 1'b1);
        a = 9'($urandom);
        b = 9'($urandom);
        brk = 1'b1;
        @(negedge clk);
        push(a);
        push(b);
        brk = 1'b0;
        @(negedge clk);
        saved = cur;
        expect_frame("cfg old", a, saved, 5, 2, waited);
        expect_frame("cfg new", b, alt, -1, 0, waited);
        check("cfg gap", 32'(waited), 32'd0);

        // Disable mid-DATA aborts, re-enable sends the next word
        cur = mk_cfg(16'd3, 3'd3, 1'b0, 2'd0, 1'b0);
        a = 9'($urandom);
        b = 9'($urandom);
        brk = 1'b1;
        @(negedge clk);
        push(a);
        push(b);
        brk = 1'b0;
        @(negedge clk);
        waited = 0;
        while (tx !== 1'b0 && waited < WAIT_MAX) begin
            @(negedge clk);
            waited++;
        end
        check("abort start", 32'(tx), 32'd0);
        repeat (10) @(negedge clk);
        check("abort pre busy", 32'(busy), 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("abort tx", 32'(tx), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort lvl", 32'(level), 32'd1);
        check("abort done", 32'(done), 32'd0);
        check("abort ready", 32'(tx_ready), 32'd0);
        repeat (5) @(negedge clk);
        en = 1'b1;
        expect_frame("resend", b, cur, -1, 0, waited);

        // Flush mid-frame with a concurrent push
        cur = mk_cfg(16'd1, 3'd3, 1'b0, 2'd0, 1'b0);
        a = 9'($urandom);
        brk = 1'b1;
        @(negedge clk);
        push(a);
        push(9'($urandom));
        push(9'($urandom));
        brk = 1'b0;
        @(negedge clk);
        expect_frame("clr", a, cur, 6, 1, waited);
        check("clr lvl", 32'(level), 32'd0);
        check("clr busy", 32'(busy), 32'd0);
        watch_idle("clr none", 40);

        check("done pulses", 32'(pulses), 32'(frames_done));
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
